// File: rtl/step_cmd_sequencer.sv
// Segment FIFO and launch sequencer feeding the clk_gen step-pulse generator.
// Per segment: drive dir, honour driver setup time on a direction change, load, pulse start, await finish.

module step_cmd_sequencer #(
    parameter int DEPTH     = 16,
    parameter int DIR_SETUP = 50,
    parameter int ACK_TMO   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_dir,
    input  logic [31:0]            wr_reduction,
    input  logic [30:0]            wr_count,
    input  logic                   enable,
    input  logic                   abort,
    output logic [31:0]            gen_reduction,
    output logic [30:0]            gen_count,
    output logic                   gen_start,
    input  logic                   gen_finish,
    output logic                   dir,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            seg_done,
    output logic                   err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int TMR_MAX = (DIR_SETUP > ACK_TMO) ? DIR_SETUP : ACK_TMO;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] SETUP_LAST = TW'(DIR_SETUP - 1);
    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_START,
        S_ACK,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic        dir;
        logic [31:0] reduction;
        logic [30:0] count;
    } seg_t;

    state_t          state;
    state_t          state_next;
    seg_t            mem [DEPTH];
    seg_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tmr;
    logic            dir_primed;
    logic            push;
    logic            pop;
    logic            load;
    logic            seg_inc;
    logic            err_set;

    assign wr_ready  = (level != FULL_LEVEL);
    assign push      = wr_valid && wr_ready && !abort;
    assign head      = mem[rd_ptr];
    assign gen_start = (state == S_START);
    assign busy      = (state != S_IDLE);

    // NOTE: storage is never read before it is written, so it carries no reset and maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dir: wr_dir, reduction: wr_reduction, count: wr_count};
        end
    end

    // NOTE: every register uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: all outputs get a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        seg_inc    = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!abort && enable && (level != '0) && gen_finish && !err) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    pop = 1'b1;
                    if (head.count == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        load = 1'b1;
                        if (!dir_primed || (head.dir != dir)) state_next = S_SETUP;
                        else                                  state_next = S_START;
                    end
                end
            end
            S_SETUP: begin
                if (abort)                  state_next = S_IDLE;
                else if (tmr == SETUP_LAST) state_next = S_START;
            end
            // The start pulse is already on the wire here, so an abort must wait for the generator.
            S_START: begin
                if (abort) state_next = S_DRAIN;
                else       state_next = S_ACK;
            end
            S_ACK: begin
                if (abort) begin
                    state_next = S_DRAIN;
                end else if (!gen_finish) begin
                    state_next = S_RUN;
                end else if (tmr == ACK_LAST) begin
                    err_set    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_DRAIN;
                end else if (gen_finish) begin
                    seg_inc    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (gen_finish) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shared cycle timer for SETUP and ACK; restarts on every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else if (state_next != state) begin
            tmr <= '0;
        end else if ((state == S_SETUP) || (state == S_ACK)) begin
            tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_reduction <= '0;
            gen_count     <= '0;
            dir           <= 1'b0;
            dir_primed    <= 1'b0;
            seg_done      <= '0;
            err           <= 1'b0;
        end else begin
            if (load) begin
                gen_reduction <= head.reduction;
                gen_count     <= head.count;
                dir           <= head.dir;
                dir_primed    <= 1'b1;
            end
            if (seg_inc) seg_done <= seg_done + 32'd1;
            if (err_set) err      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_step_cmd_sequencer.sv
// Randomized scoreboard bench for step_cmd_sequencer with a behavioural clk_gen model.
// Launched segments are predicted in FIFO order and checked when gen_start is seen.

module tb_step_cmd_sequencer;

    localparam int DEPTH     = 16;
    localparam int DIR_SETUP = 50;
    localparam int ACK_TMO   = 4;
    localparam int LW        = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic        d;
        logic [31:0] r;
        logic [30:0] c;
    } tseg_t;

    logic          clk          = 1'b0;
    logic          reset_n      = 1'b0;
    logic          wr_valid     = 1'b0;
    logic          wr_dir       = 1'b0;
    logic [31:0]   wr_reduction = '0;
    logic [30:0]   wr_count     = '0;
    logic          enable       = 1'b0;
    logic          abort        = 1'b0;
    logic          gen_finish   = 1'b1;
    logic          wr_ready;
    logic [31:0]   gen_reduction;
    logic [30:0]   gen_count;
    logic          gen_start;
    logic          dir;
    logic          busy;
    logic [LW-1:0] level;
    logic [31:0]   seg_done;
    logic          err;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    tseg_t exp_q[$];

    // clk_gen model state
    int run_left    = 0;
    bit run_aborted = 1'b0;
    int model_done  = 0;
    bit stuck       = 1'b0;

    // monitor state
    tseg_t e;
    bit    dir_pend    = 1'b0;
    int    dir_chg_cyc = 0;
    int    rise_cyc    = 0;
    int    n_starts    = 0;
    logic  last_dir    = 1'b0;
    logic  last_start  = 1'b0;
    logic  last_fin    = 1'b1;

    step_cmd_sequencer #(
        .DEPTH(DEPTH),
        .DIR_SETUP(DIR_SETUP),
        .ACK_TMO(ACK_TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_dir(wr_dir),
        .wr_reduction(wr_reduction),
        .wr_count(wr_count),
        .enable(enable),
        .abort(abort),
        .gen_reduction(gen_reduction),
        .gen_count(gen_count),
        .gen_start(gen_start),
        .gen_finish(gen_finish),
        .dir(dir),
        .busy(busy),
        .level(level),
        .seg_done(seg_done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Generator model: drops finish after sampling start, raises it after a count-derived run.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_finish  <= 1'b1;
            run_left    <= 0;
            run_aborted <= 1'b0;
            model_done  <= 0;
        end else if (gen_start && !stuck) begin
            gen_finish  <= 1'b0;
            run_left    <= 2 * int'(gen_count[2:0]) + 1;
            run_aborted <= abort;
        end else if (!gen_finish) begin
            if (abort) run_aborted <= 1'b1;
            if (run_left <= 1) begin
                gen_finish <= 1'b1;
                if (!run_aborted && !abort) model_done <= model_done + 1;
            end else begin
                run_left <= run_left - 1;
            end
        end
    end

    // Monitor: every start pulse must match the scoreboard head and the driver setup time.
    always @(negedge clk) begin
        if (!reset_n) begin
            dir_pend   = 1'b0;
            last_dir   = 1'b0;
            last_start = 1'b0;
            last_fin   = 1'b1;
        end else begin
            if (dir != last_dir) begin
                dir_pend    = 1'b1;
                dir_chg_cyc = cyc;
            end
            if (gen_finish && !last_fin) rise_cyc = cyc;
            if (gen_start) begin
                n_starts++;
                check("start pulse width", 64'(last_start), 64'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected start", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("start dir", 64'(dir), 64'(e.d));
                    check("start reduction", 64'(gen_reduction), 64'(e.r));
                    check("start count", 64'(gen_count), 64'(e.c));
                end
                if (dir_pend) begin
                    check("dir setup cycles", 64'(cyc - dir_chg_cyc), 64'(DIR_SETUP));
                    dir_pend = 1'b0;
                end
            end
            last_dir   = dir;
            last_start = gen_start;
            last_fin   = gen_finish;
        end
    end

    task automatic write_seg(input logic d, input logic [31:0] r, input logic [30:0] c, input bit push_exp);
        tseg_t s;
        s.d = d;
        s.r = r;
        s.c = c;
        wr_valid     = 1'b1;
        wr_dir       = d;
        wr_reduction = r;
        wr_count     = c;
        if (push_exp && (c != '0)) exp_q.push_back(s);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (gen_start) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 64'(seen), 64'(1));
    endtask

    task automatic wait_idle(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy && (level == '0) && gen_finish) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 64'(seen), 64'(1));
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
        check("abort level", 64'(level), 64'(0));
        check("abort wr_ready", 64'(wr_ready), 64'(1));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " level"}, 64'(level), 64'(0));
        check({tag, " wr_ready"}, 64'(wr_ready), 64'(1));
        check({tag, " gen_start"}, 64'(gen_start), 64'(0));
        check({tag, " gen_reduction"}, 64'(gen_reduction), 64'(0));
        check({tag, " gen_count"}, 64'(gen_count), 64'(0));
        check({tag, " dir"}, 64'(dir), 64'(0));
        check({tag, " seg_done"}, 64'(seg_done), 64'(0));
        check({tag, " err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int d0;
        int t0;
        int bad;
        int n;

        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // single segment with a direction change
        enable = 1'b1;
        write_seg(1'b1, 32'd3, 31'd2, 1'b1);
        wait_start(200, "t1 start");
        wait_idle(200, "t1 idle");
        check("t1 seg_done", 64'(seg_done), 64'(1));
        check("t1 starts", 64'(n_starts), 64'(1));
        check("t1 busy", 64'(busy), 64'(0));

        // three same-direction segments: back-to-back launch latency
        enable = 1'b0;
        for (int i = 0; i < 3; i++) write_seg(1'b0, $urandom, 31'($urandom_range(1, 3)), 1'b1);
        check("t2 level", 64'(level), 64'(3));
        enable = 1'b1;
        wait_start(200, "t2 start0");
        for (int k = 1; k < 3; k++) begin
            wait_start(200, "t2 start b2b");
            check("t2 b2b latency", 64'(cyc - rise_cyc), 64'(3));
        end
        wait_idle(200, "t2 idle");
        check("t2 level drained", 64'(level), 64'(0));
        check("t2 seg_done", 64'(seg_done), 64'(model_done));

        // overfill with launching disabled
        enable = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            check("t3 wr_ready", 64'(wr_ready), 64'(i < DEPTH));
            write_seg(1'($urandom_range(0, 1)), $urandom, 31'($urandom_range(1, 5)), 1'b0);
        end
        check("t3 level full", 64'(level), 64'(DEPTH));
        abort_pulse();

        // abort during RUN with five queued
        enable = 1'b1;
        write_seg(1'b1, $urandom, 31'd7, 1'b1);
        wait_start(200, "t4 start");
        for (int i = 0; i < 5; i++) write_seg(1'($urandom_range(0, 1)), $urandom, 31'($urandom_range(1, 5)), 1'b1);
        check("t4 level queued", 64'(level), 64'(5));
        d0 = model_done;
        abort_pulse();
        check("t4 busy after abort", 64'(busy), 64'(1));
        bad = 0;
        for (int i = 0; i < 100 && !gen_finish; i++) begin
            if (!busy) bad++;
            @(negedge clk);
        end
        check("t4 drain holds busy", 64'(bad), 64'(0));
        wait_idle(50, "t4 idle");
        check("t4 seg_done unchanged", 64'(seg_done), 64'(d0));
        check("t4 scoreboard empty", 64'(exp_q.size()), 64'(0));

        // zero-count segment is discarded
        enable = 1'b0;
        write_seg(1'b0, $urandom, 31'd4, 1'b1);
        write_seg(1'b0, $urandom, 31'd0, 1'b1);
        write_seg(1'b0, $urandom, 31'd4, 1'b1);
        s0 = n_starts;
        d0 = model_done;
        enable = 1'b1;
        wait_idle(500, "t5 idle");
        check("t5 starts", 64'(n_starts - s0), 64'(2));
        check("t5 seg_done", 64'(seg_done), 64'(d0 + 2));

        // randomized bursts
        for (int it = 0; it < 12; it++) begin
            enable = (it % 3 != 0);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                write_seg(1'($urandom_range(0, 1)), $urandom, 31'($urandom_range(0, 5)), 1'b1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            enable = 1'b1;
            wait_idle(3000, "rand idle");
            check("rand level", 64'(level), 64'(0));
            check("rand seg_done", 64'(seg_done), 64'(model_done));
            check("rand scoreboard empty", 64'(exp_q.size()), 64'(0));
        end

        // generator never acknowledges: sticky error, no further launches
        stuck = 1'b1;
        d0 = model_done;
        write_seg(1'b1, $urandom, 31'd3, 1'b1);
        wait_start(200, "t6 start");
        repeat (ACK_TMO) @(negedge clk);
        check("t6 err before timeout", 64'(err), 64'(0));
        @(negedge clk);
        check("t6 err set", 64'(err), 64'(1));
        check("t6 busy after err", 64'(busy), 64'(0));
        write_seg(1'b0, $urandom, 31'd2, 1'b0);
        s0 = n_starts;
        repeat (100) @(negedge clk);
        check("t6 no launch", 64'(n_starts), 64'(s0));
        check("t6 level held", 64'(level), 64'(1));
        check("t6 err sticky", 64'(err), 64'(1));
        check("t6 seg_done", 64'(seg_done), 64'(d0));
        stuck = 1'b0;
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset("t6 reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // first segment after reset takes SETUP even with dir unchanged
        enable = 1'b1;
        t0 = cyc;
        write_seg(1'b0, $urandom, 31'd2, 1'b1);
        wait_start(200, "t7 start");
        check("t7 first setup latency", 64'(cyc - t0), 64'(DIR_SETUP + 3));
        wait_idle(200, "t7 idle");
        check("t7 seg_done", 64'(seg_done), 64'(1));

        // asynchronous reset in the middle of a run
        write_seg(1'b1, $urandom, 31'd5, 1'b1);
        wait_start(200, "t8 start");
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset("t8 async reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t8 idle after reset", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
